// File: rtl/vga_plot_scanout_pkg.sv
// Display timing, framebuffer geometry and the row*160+col address helper for the plot scan-out.
// Latency: none (constants and one combinational function).
// Backpressure: n/a.
package vga_plot_scanout_pkg;
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_TOT  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_V_TOT  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int FB_W_DEF = 160;
    localparam int FB_H_DEF = 120;
    localparam int ADDR_W   = 15;
    localparam int CNT_W    = 10;

    typedef logic [ADDR_W-1:0] fb_addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [2:0]        rgb_t;
    typedef enum logic {ST_CLEAR, ST_RUN} clr_state_t;

    // row*160 + col using shifts and adds only.
    function automatic fb_addr_t fb_addr(input logic [7:0] col, input logic [7:0] row);
        fb_addr_t r;
        r = {7'd0, row};
        return (r << 7) + (r << 5) + {7'd0, col};
    endfunction
endpackage

// File: rtl/vga_plot_scanout_ram.sv
// Simple dual-port framebuffer: one write port, one registered read port, single clock.
// Latency: read data valid one clock after a cycle with re high; collisions return the old word.
// Backpressure: none; every write and read is accepted.
module plot_framebuffer_ram
    import vga_plot_scanout_pkg::*;
#(
    parameter int DEPTH = FB_W_DEF * FB_H_DEF,
    parameter int DW    = 3
) (
    input  logic           clock,
    input  logic           we,
    input  fb_addr_t       waddr,
    input  logic [DW-1:0]  wdat,
    input  logic           re,
    input  fb_addr_t       raddr,
    output logic [DW-1:0]  rdat
);
    logic [DW-1:0] mem [DEPTH];

    // Both ports sample mem before the write lands, giving read-old-data.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
        if (re) begin
            rdat <= mem[raddr];
        end
    end
endmodule

// File: rtl/vga_plot_scanout.sv
// Plot receiver: clears a 160x120x3 framebuffer after reset, then scans it out as 640x480 VGA at 4x4 replication.
// Latency: RGB/sync/blank lag the H/V counters by exactly one pixel tick; a plot shows up on the next read of its address.
// Backpressure: none; plots arriving while busy or out of range are dropped.
module vga_plot_scanout
    import vga_plot_scanout_pkg::*;
#(
    parameter int   FB_W      = FB_W_DEF,
    parameter int   FB_H      = FB_H_DEF,
    parameter rgb_t BG_COLOUR = 3'b000,
    // Display timing; defaults are 640x480@60.
    parameter int   H_VIS     = VGA_H_VIS,
    parameter int   H_FP      = VGA_H_FP,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BP      = VGA_H_BP,
    parameter int   V_VIS     = VGA_V_VIS,
    parameter int   V_FP      = VGA_V_FP,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BP      = VGA_V_BP
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       busy,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);
    localparam cnt_t     H_LAST   = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t     V_LAST   = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t     HS_BEGIN = cnt_t'(H_VIS + H_FP);
    localparam cnt_t     HS_END   = cnt_t'(H_VIS + H_FP + H_SYNC);
    localparam cnt_t     VS_BEGIN = cnt_t'(V_VIS + V_FP);
    localparam cnt_t     VS_END   = cnt_t'(V_VIS + V_FP + V_SYNC);
    localparam cnt_t     H_VIS_C  = cnt_t'(H_VIS);
    localparam cnt_t     V_VIS_C  = cnt_t'(V_VIS);
    localparam fb_addr_t CLR_LAST = fb_addr_t'(FB_W * FB_H - 1);
    localparam logic [7:0] X_LIM  = 8'(FB_W);
    localparam logic [6:0] Y_LIM  = 7'(FB_H);

    logic       tick;
    cnt_t       hcount;
    cnt_t       vcount;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       vis_nxt;
    logic       hs_q;
    logic       vs_q;
    logic       blank_n_q;
    rgb_t       pix_q;
    fb_addr_t   raddr;
    fb_addr_t   host_addr;
    logic       host_ok;
    clr_state_t state;
    clr_state_t state_nxt;
    fb_addr_t   clr_addr;
    fb_addr_t   clr_addr_nxt;
    logic       we;
    fb_addr_t   waddr;
    rgb_t       wdat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick <= 1'b0;
        end else begin
            tick <= ~tick;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + cnt_t'(1);
            end else begin
                hcount <= hcount + cnt_t'(1);
            end
        end
    end

    assign hs_nxt  = !((hcount >= HS_BEGIN) && (hcount < HS_END));
    assign vs_nxt  = !((vcount >= VS_BEGIN) && (vcount < VS_END));
    assign vis_nxt = (hcount < H_VIS_C) && (vcount < V_VIS_C);
    assign raddr   = fb_addr(hcount[9:2], vcount[9:2]);

    // Sync/blank are registered on the same tick as the RAM read so all outputs line up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (tick) begin
            hs_q      <= hs_nxt;
            vs_q      <= vs_nxt;
            blank_n_q <= vis_nxt;
        end
    end

    assign host_addr = fb_addr(x, {1'b0, y});
    assign host_ok   = (x < X_LIM) && (y < Y_LIM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        we           = 1'b0;
        waddr        = host_addr;
        wdat         = colour;
        case (state)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = clr_addr;
                wdat  = BG_COLOUR;
                if (clr_addr == CLR_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    clr_addr_nxt = clr_addr + fb_addr_t'(1);
                end
            end
            ST_RUN: begin
                we = plot && host_ok;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    plot_framebuffer_ram #(
        .DEPTH (FB_W * FB_H),
        .DW    (3)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdat  (wdat),
        .re    (tick),
        .raddr (raddr),
        .rdat  (pix_q)
    );

    assign busy        = (state == ST_CLEAR);
    assign VGA_CLK     = tick;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = blank_n_q ? {10{pix_q[2]}} : 10'd0;
    assign VGA_G       = blank_n_q ? {10{pix_q[1]}} : 10'd0;
    assign VGA_B       = blank_n_q ? {10{pix_q[0]}} : 10'd0;
endmodule

// File: tb/tb_vga_plot_scanout.sv
// Directed bench for vga_plot_scanout using a shortened raster (56x20 ticks) and a visible background colour.
module tb_vga_plot_scanout;
    localparam int H_VIS  = 40;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 8;
    localparam int H_BP   = 4;
    localparam int H_TOT  = 56;
    localparam int V_VIS  = 12;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 4;
    localparam int V_TOT  = 20;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam logic [2:0] BG = 3'b010;
    localparam int ON = 'h3FF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       busy;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [9:0] VGA_R;
    logic [9:0] VGA_G;
    logic [9:0] VGA_B;

    int n_chk = 0;
    int n_err = 0;
    int cyc;

    vga_plot_scanout #(
        .FB_W(160), .FB_H(120), .BG_COLOUR(BG),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clock(clock), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #10 clock = ~clock;

    // Clock edges since reset release; pixel k is on the outputs after edges 2+2k and 3+2k of each frame.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b);
        chk({tag, "_R"}, int'(VGA_R), r);
        chk({tag, "_G"}, int'(VGA_G), g);
        chk({tag, "_B"}, int'(VGA_B), b);
    endtask

    task automatic wait_px(input int h, input int v);
        int target;
        int guard;
        target = 2 * (v * H_TOT + h);
        guard  = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(cyc >= 2 && ((cyc - 2) % (2 * FRAME)) == target) && guard < 4 * FRAME + 10);
        if (guard >= 4 * FRAME + 10) chk("wait_px_timeout", h * 1000 + v, -1);
    endtask

    // Called at the negedge where reset drops; counts cycles with busy high.
    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 30000) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        x = 8'(px);
        y = 7'(py);
        colour = c;
        plot = 1'b1;
        @(negedge clock);
        plot = 1'b0;
    endtask

    initial begin
        int n;
        int hs_lo, vs_lo, vis;

        // 1: reset values, clear sweep length, cleared contents
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 1);
        chk("rst_vgaclk", int'(VGA_CLK), 0);
        chk("rst_hs", int'(VGA_HS), 1);
        chk("rst_vs", int'(VGA_VS), 1);
        chk("rst_blank_n", int'(VGA_BLANK_N), 0);
        chk("rst_r", int'(VGA_R), 0);
        chk("sync_n", int'(VGA_SYNC_N), 0);
        reset = 1'b0;
        busy_len(n);
        chk("busy_len", n, 19200);
        chk("mem0", int'(dut.u_ram.mem[0]), int'(BG));
        chk("mem9600", int'(dut.u_ram.mem[9600]), int'(BG));
        chk("mem19199", int'(dut.u_ram.mem[19199]), int'(BG));

        // 2: red pixel at (0,0) fills the first 4x4 block
        plot_px(0, 0, 3'b100);
        wait_px(0, 0);
        chk("px00_blank_n", int'(VGA_BLANK_N), 1);
        chk_rgb("px00", ON, 0, 0);
        wait_px(3, 3);
        chk_rgb("px33", ON, 0, 0);
        wait_px(4, 0);
        chk_rgb("px40", 0, ON, 0);

        // 3: sync/blank edges and per-frame counts
        wait_px(H_VIS - 1, 0);  chk("blank_last_vis", int'(VGA_BLANK_N), 1);
        wait_px(H_VIS, 0);      chk("blank_h_fp", int'(VGA_BLANK_N), 0);
        wait_px(H_VIS + H_FP - 1, 0);          chk("hs_before", int'(VGA_HS), 1);
        wait_px(H_VIS + H_FP, 0);              chk("hs_start", int'(VGA_HS), 0);
        wait_px(H_VIS + H_FP + H_SYNC - 1, 0); chk("hs_last", int'(VGA_HS), 0);
        wait_px(H_VIS + H_FP + H_SYNC, 0);     chk("hs_end", int'(VGA_HS), 1);
        wait_px(0, V_VIS);                      chk("blank_v_fp", int'(VGA_BLANK_N), 0);
        wait_px(0, V_VIS + V_FP - 1);           chk("vs_before", int'(VGA_VS), 1);
        wait_px(0, V_VIS + V_FP);               chk("vs_start", int'(VGA_VS), 0);
        wait_px(0, V_VIS + V_FP + V_SYNC);      chk("vs_end", int'(VGA_VS), 1);
        wait_px(0, 0);
        hs_lo = 0; vs_lo = 0; vis = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (!VGA_HS) hs_lo++;
            if (!VGA_VS) vs_lo++;
            if (VGA_BLANK_N) vis++;
            @(negedge clock);
        end
        chk("hs_low_samples", hs_lo, 2 * H_SYNC * V_TOT);
        chk("vs_low_samples", vs_lo, 2 * V_SYNC * H_TOT);
        chk("visible_samples", vis, 2 * H_VIS * V_VIS);

        // 4: out-of-range plots are dropped without wrapping
        plot_px(160, 5, 3'b111);
        plot_px(3, 120, 3'b111);
        chk("oor_960", int'(dut.u_ram.mem[960]), int'(BG));
        chk("oor_959", int'(dut.u_ram.mem[959]), int'(BG));
        chk("oor_19043", int'(dut.u_ram.mem[19043]), int'(BG));
        chk("oor_19199", int'(dut.u_ram.mem[19199]), int'(BG));

        // 5: write (9,2) on the very edge the scanner first reads it
        wait_px(35, 8);
        @(negedge clock);
        x = 8'd9; y = 7'd2; colour = 3'b011; plot = 1'b1;
        @(negedge clock);
        plot = 1'b0;
        chk_rgb("coll_old", 0, ON, 0);
        wait_px(37, 8);
        chk_rgb("coll_after", 0, ON, ON);
        wait_px(36, 8);
        chk_rgb("coll_next_frame", 0, ON, ON);

        // 6: reset during the sweep at address 5000
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5000) @(negedge clock);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_blank_n", int'(VGA_BLANK_N), 1);
        chk("pre_rst_g", int'(VGA_G), ON);
        #3 reset = 1'b1;
        #1;
        chk("arst_vgaclk", int'(VGA_CLK), 0);
        chk("arst_hs", int'(VGA_HS), 1);
        chk("arst_vs", int'(VGA_VS), 1);
        chk("arst_blank_n", int'(VGA_BLANK_N), 0);
        chk("arst_g", int'(VGA_G), 0);
        chk("arst_busy", int'(busy), 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        busy_len(n);
        chk("busy_len_restart", n, 19200);
        chk("mem0_recleared", int'(dut.u_ram.mem[0]), int'(BG));
        chk("mem329_recleared", int'(dut.u_ram.mem[329]), int'(BG));
        wait_px(0, 0);
        chk_rgb("px00_recleared", 0, ON, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
